// File: rtl/gain_n_voies_pkg.sv
// ---------------------------------------------------------------------------
// gain_n_voies_pkg
// Shared constants and the rounding/saturation helper for the N-channel gain
// stream datapath.
//   Q_FRAC      : number of fractional bits in a gain (Q2.14)
//   GAIN_UNITY  : gain encoding of 1.0
//   sat_res_t   : rounded result plus a flag telling whether it was clipped
//   sat_round() : round-half-up a Q_FRAC-scaled product and clip it to a
//                 signed data_w-bit range
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package gain_n_voies_pkg;

   localparam int          Q_FRAC     = 14;
   localparam logic [15:0] GAIN_UNITY = 16'h4000;

   typedef struct packed {
      logic signed [31:0] res;
      logic               sat;
   } sat_res_t;

   // The product is passed sign-extended to 64 bits so one function serves
   // every DATA_W/GAIN_W combination; the caller keeps the low data_w bits.
   function automatic sat_res_t sat_round(input logic signed [63:0] product,
                                          input int                 data_w);
      logic signed [63:0] rounded;
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      sat_res_t           r;
      rounded = (product + (64'sd1 <<< (Q_FRAC - 1))) >>> Q_FRAC;
      max_v   = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      min_v   = -(64'sd1 <<< (data_w - 1));
      r.res   = rounded[31:0];
      r.sat   = 1'b0;
      if (rounded > max_v) begin
         r.res = max_v[31:0];
         r.sat = 1'b1;
      end else if (rounded < min_v) begin
         r.res = min_v[31:0];
         r.sat = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/gain_n_voies_stream_mult.sv
// ---------------------------------------------------------------------------
// gnv_mult_stage
// Two-register multiply / round / saturate slice with AXI-Stream style
// valid/ready. S1 holds the full-width product, S2 the clipped result.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake (in_ready is combinational
//                         from out_ready)
//   in_data, in_gain      signed sample and signed Q2.14 gain
//   in_last, in_user      sideband carried alongside the sample
//   out_valid/out_ready   downstream handshake
//   out_data, out_last, out_user   registered result and sideband
//   sat_pulse_o           one-cycle pulse when a clipped result loads S2
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module gnv_mult_stage
   import gain_n_voies_pkg::*;
#(
   parameter int DATA_W = 24,
   parameter int GAIN_W = 16,
   parameter int USER_W = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic signed [GAIN_W-1:0] in_gain,
   input  logic                     in_last,
   input  logic        [USER_W-1:0] in_user,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic        [DATA_W-1:0] out_data,
   output logic                     out_last,
   output logic        [USER_W-1:0] out_user,
   output logic                     sat_pulse_o
);

   localparam int PROD_W = DATA_W + GAIN_W;

   logic                     adv1, adv2;
   logic                     s1_valid_q, s1_valid_d;
   logic signed [PROD_W-1:0] s1_prod_q,  s1_prod_d;
   logic                     s1_last_q,  s1_last_d;
   logic        [USER_W-1:0] s1_user_q,  s1_user_d;
   logic                     s2_valid_q, s2_valid_d;
   logic        [DATA_W-1:0] s2_data_q,  s2_data_d;
   logic                     s2_last_q,  s2_last_d;
   logic        [USER_W-1:0] s2_user_q,  s2_user_d;
   sat_res_t                 sr;
   logic                     unused_sr_bits;

   // A stage may load when it is empty or when the stage after it drains
   // this cycle; this gives full throughput with no bubbles.
   always_comb begin
      adv2        = !s2_valid_q || out_ready;
      adv1        = !s1_valid_q || adv2;
      s1_valid_d  = s1_valid_q;
      s1_prod_d   = s1_prod_q;
      s1_last_d   = s1_last_q;
      s1_user_d   = s1_user_q;
      s2_valid_d  = s2_valid_q;
      s2_data_d   = s2_data_q;
      s2_last_d   = s2_last_q;
      s2_user_d   = s2_user_q;
      sat_pulse_o = 1'b0;
      sr          = sat_round(64'(s1_prod_q), DATA_W);
      if (adv1) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_prod_d = PROD_W'(in_data) * PROD_W'(in_gain);
            s1_last_d = in_last;
            s1_user_d = in_user;
         end
      end
      if (adv2) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d   = sr.res[DATA_W-1:0];
            s2_last_d   = s1_last_q;
            s2_user_d   = s1_user_q;
            sat_pulse_o = sr.sat;
         end
      end
   end

   assign unused_sr_bits = ^sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_prod_q  <= '0;
         s1_last_q  <= 1'b0;
         s1_user_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_last_q  <= 1'b0;
         s2_user_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_prod_q  <= s1_prod_d;
         s1_last_q  <= s1_last_d;
         s1_user_q  <= s1_user_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_last_q  <= s2_last_d;
         s2_user_q  <= s2_user_d;
      end
   end

   assign in_ready  = adv1;
   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_last  = s2_last_q;
   assign out_user  = s2_user_q;

endmodule

// File: rtl/gain_n_voies_stream.sv
// ---------------------------------------------------------------------------
// gain_n_voies_stream
// Streaming N-channel gain stage. TDM-interleaved samples arrive one channel
// per beat; each is scaled by its channel gain, rounded and saturated.
// Optional feature macro: GNV_SAT_CNT_EN (saturation counter on sat_cnt_o).
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   gains_i               channel k gain at [k*GAIN_W +: GAIN_W], Q2.14
//   s_axis_*              input stream (tdata, tvalid, tlast, tready)
//   m_axis_*              output stream (tdata, tvalid, tlast, tuser=channel,
//                         tready)
//   frame_err_o           sticky framing error, cleared only by reset
//   sat_cnt_o             saturated-beat count (0 when the macro is absent)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module gain_n_voies_stream
   import gain_n_voies_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int DATA_W = 24,
   parameter int GAIN_W = 16
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [N_CH*GAIN_W-1:0]   gains_i,
   input  logic [DATA_W-1:0]        s_axis_tdata,
   input  logic                     s_axis_tvalid,
   input  logic                     s_axis_tlast,
   output logic                     s_axis_tready,
   output logic [DATA_W-1:0]        m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic [$clog2(N_CH)-1:0]  m_axis_tuser,
   output logic                     frame_err_o,
   output logic [15:0]              sat_cnt_o
);

   localparam int CH_W = $clog2(N_CH);

   logic              hs;
   logic              last_ch;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [GAIN_W-1:0] gain_sh_q [N_CH];
   logic [GAIN_W-1:0] gain_sh_d [N_CH];
   logic [GAIN_W-1:0] cur_gain;
   logic              frame_err_q, frame_err_d;
   logic              sat_pulse;

   // Channel 0 bypasses the shadow so it sees the gains being captured on
   // its own handshake; later channels read the frame's snapshot, which
   // makes a mid-frame register write take effect on the next frame.
   // The counter resyncs on tlast even when tlast arrives early.
   always_comb begin
      hs          = s_axis_tvalid && s_axis_tready;
      last_ch     = (ch_q == CH_W'(N_CH - 1));
      ch_d        = ch_q;
      gain_sh_d   = gain_sh_q;
      frame_err_d = frame_err_q;
      cur_gain    = gain_sh_q[ch_q];
      if (ch_q == '0) begin
         cur_gain = gains_i[GAIN_W-1:0];
      end
      if (hs) begin
         if (ch_q == '0) begin
            for (int k = 0; k < N_CH; k++) begin
               gain_sh_d[k] = gains_i[k*GAIN_W +: GAIN_W];
            end
         end
         if (s_axis_tlast || last_ch) begin
            ch_d = '0;
         end else begin
            ch_d = ch_q + CH_W'(1);
         end
         if (s_axis_tlast != last_ch) begin
            frame_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         ch_q        <= '0;
         frame_err_q <= 1'b0;
         for (int k = 0; k < N_CH; k++) begin
            gain_sh_q[k] <= GAIN_W'(GAIN_UNITY);
         end
      end else begin
         ch_q        <= ch_d;
         frame_err_q <= frame_err_d;
         gain_sh_q   <= gain_sh_d;
      end
   end

   gnv_mult_stage #(
      .DATA_W (DATA_W),
      .GAIN_W (GAIN_W),
      .USER_W (CH_W)
   ) u_mult (
      .clk         (aclk),
      .rst         (areset),
      .in_valid    (s_axis_tvalid),
      .in_ready    (s_axis_tready),
      .in_data     (s_axis_tdata),
      .in_gain     (cur_gain),
      .in_last     (s_axis_tlast),
      .in_user     (ch_q),
      .out_valid   (m_axis_tvalid),
      .out_ready   (m_axis_tready),
      .out_data    (m_axis_tdata),
      .out_last    (m_axis_tlast),
      .out_user    (m_axis_tuser),
      .sat_pulse_o (sat_pulse)
   );

   assign frame_err_o = frame_err_q;

`ifdef GNV_SAT_CNT_EN
   logic [15:0] sat_cnt_q, sat_cnt_d;

   // Counts clipped beats as they load the output register; sticks at the
   // top value instead of wrapping.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (sat_pulse && (sat_cnt_q != 16'hFFFF)) begin
         sat_cnt_d = sat_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         sat_cnt_q <= 16'd0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign sat_cnt_o = sat_cnt_q;
`else
   logic unused_sat_pulse;
   assign unused_sat_pulse = sat_pulse;
   assign sat_cnt_o        = 16'd0;
`endif

endmodule

// File: tb/tb_gain_n_voies_stream.sv
// ---------------------------------------------------------------------------
// tb_gain_n_voies_stream
// Directed bench for gain_n_voies_stream (N_CH=4, DATA_W=24, GAIN_W=16).
// Inputs are driven 1 ns after the rising edge; a negedge monitor compares
// every output handshake against a queue of hand-computed expected beats and
// checks that the output holds steady while stalled.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gain_n_voies_stream;

   localparam logic [63:0] G_UNITY = 64'h4000_4000_4000_4000;
   localparam logic [63:0] G_HALF  = 64'h2000_2000_2000_2000;

   logic        aclk;
   logic        areset;
   logic [63:0] gains_i;
   logic [23:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tlast;
   logic        s_axis_tready;
   logic [23:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic [1:0]  m_axis_tuser;
   logic        frame_err_o;
   logic [15:0] sat_cnt_o;

   logic rand_rdy  = 1'b0;
   logic rdy_force = 1'b0;
   logic rnd_bit   = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [23:0] data;
      logic [1:0]  user;
      logic        last;
   } beat_t;

   typedef struct {
      logic [63:0] gains;
      logic [23:0] din;
      logic [23:0] dout;
      logic [1:0]  ch;
   } vec_t;

   beat_t exp_q[$];
   vec_t  vecs[12];

   gain_n_voies_stream #(
      .N_CH   (4),
      .DATA_W (24),
      .GAIN_W (16)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .gains_i       (gains_i),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .frame_err_o   (frame_err_o),
      .sat_cnt_o     (sat_cnt_o)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Random downstream back-pressure, enabled only during the stall test.
   always @(posedge aclk) begin
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
   end
   assign m_axis_tready = rand_rdy ? rnd_bit : rdy_force;

   task automatic check_output(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Holds one beat on the input until it is accepted (bounded).
   task automatic apply_stimulus(input logic [23:0] d, input logic l);
      int   n    = 0;
      logic done = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      while (!done) begin
         @(negedge aclk);
         done = s_axis_tready;
         @(posedge aclk);
         #1;
         n++;
         if (!done && n > 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout: got no s_axis_tready, expected it within 200 cycles");
            done = 1'b1;
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic expect_beat(input logic [23:0] d, input logic [1:0] u,
                              input logic l);
      beat_t b;
      b.data = d;
      b.user = u;
      b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge aclk);
         #1;
         n++;
      end
      check_output({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Output monitor: compares handshakes with the queue and checks stall
   // stability against the previous negedge snapshot.
   logic        prev_stall = 1'b0;
   logic [27:0] prev_snap  = '0;
   always @(negedge aclk) begin
      beat_t e;
      if (areset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_output("stall_hold",
                         32'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}),
                         32'(prev_snap));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_beat: got data 0x%0h user %0d, expected no output",
                        m_axis_tdata, m_axis_tuser);
            end else begin
               e = exp_q.pop_front();
               check_output("out_data", 32'(m_axis_tdata), 32'(e.data));
               check_output("out_user", 32'(m_axis_tuser), 32'(e.user));
               check_output("out_last", 32'(m_axis_tlast), 32'(e.last));
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_snap  = {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast};
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of test, expected it within 200 us");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Hand-computed vectors: out = floor((in*gain + 2^13) / 2^14), clipped.
      vecs[0]  = '{64'h7FFF_0000_8000_2000, 24'h000100, 24'h000080, 2'd0};
      vecs[1]  = '{64'h7FFF_0000_8000_2000, 24'h000100, 24'hFFFE00, 2'd1};
      vecs[2]  = '{64'h7FFF_0000_8000_2000, 24'h000100, 24'h000000, 2'd2};
      vecs[3]  = '{64'h7FFF_0000_8000_2000, 24'h000100, 24'h000200, 2'd3};
      vecs[4]  = '{64'h4000_7FFF_7FFF_8000, 24'h7FFFFF, 24'h800000, 2'd0};
      vecs[5]  = '{64'h4000_7FFF_7FFF_8000, 24'h7FFFFF, 24'h7FFFFF, 2'd1};
      vecs[6]  = '{64'h4000_7FFF_7FFF_8000, 24'h400000, 24'h7FFF00, 2'd2};
      vecs[7]  = '{64'h4000_7FFF_7FFF_8000, 24'h800000, 24'h800000, 2'd3};
      vecs[8]  = '{G_HALF,                  24'h000001, 24'h000001, 2'd0};
      vecs[9]  = '{G_HALF,                  24'hFFFFFF, 24'h000000, 2'd1};
      vecs[10] = '{G_HALF,                  24'h000003, 24'h000002, 2'd2};
      vecs[11] = '{G_HALF,                  24'hFFFFFD, 24'hFFFFFF, 2'd3};

      areset        = 1'b1;
      gains_i       = G_UNITY;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      rdy_force     = 1'b0;
      repeat (3) @(posedge aclk);
      #1;

      // Reset state; input ready even with the output stalled (empty pipe).
      check_output("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check_output("rst_m_tdata",  32'(m_axis_tdata),  32'd0);
      check_output("rst_m_tuser",  32'(m_axis_tuser),  32'd0);
      check_output("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
      check_output("rst_frame_err", 32'(frame_err_o),  32'd0);
      check_output("rst_sat_cnt",  32'(sat_cnt_o),     32'd0);
      check_output("rst_s_tready", 32'(s_axis_tready), 32'd1);
      areset    = 1'b0;
      rdy_force = 1'b1;

      // Test 1: unity gains, ramp 1..32; first beat timed by hand.
      expect_beat(24'd1, 2'd0, 1'b0);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 24'd1;
      s_axis_tlast  = 1'b0;
      #1;
      check_output("lat_s_tready", 32'(s_axis_tready), 32'd1);
      @(posedge aclk);
      #1;
      s_axis_tvalid = 1'b0;
      check_output("lat_cycle1_valid", 32'(m_axis_tvalid), 32'd0);
      @(posedge aclk);
      #1;
      check_output("lat_cycle2_valid", 32'(m_axis_tvalid), 32'd1);
      check_output("lat_cycle2_data",  32'(m_axis_tdata),  32'd1);
      for (int i = 2; i <= 32; i++) begin
         expect_beat(24'(i), 2'((i - 1) % 4), (i % 4) == 0);
         apply_stimulus(24'(i), (i % 4) == 0);
      end
      drain("ramp");

      // Tests 2/3: table of gain, rounding and saturation vectors.
      for (int i = 0; i < 12; i++) begin
         gains_i = vecs[i].gains;
         expect_beat(vecs[i].dout, vecs[i].ch, vecs[i].ch == 2'd3);
         apply_stimulus(vecs[i].din, vecs[i].ch == 2'd3);
      end
      drain("table");
`ifdef GNV_SAT_CNT_EN
      check_output("sat_cnt_after_table", 32'(sat_cnt_o), 32'd2);
`else
      check_output("sat_cnt_tied_zero", 32'(sat_cnt_o), 32'd0);
`endif

      // Test 4: random back-pressure with continuous input.
      gains_i  = G_UNITY;
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         expect_beat(24'h001000 + 24'(i), 2'(i % 4), (i % 4) == 3);
         apply_stimulus(24'h001000 + 24'(i), (i % 4) == 3);
      end
      drain("random_ready");
      rand_rdy = 1'b0;

      // Test 5: early tlast on channel 1.
      expect_beat(24'd5, 2'd0, 1'b0);
      apply_stimulus(24'd5, 1'b0);
      check_output("frame_err_before", 32'(frame_err_o), 32'd0);
      expect_beat(24'd6, 2'd1, 1'b1);
      apply_stimulus(24'd6, 1'b1);
      check_output("frame_err_set", 32'(frame_err_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         expect_beat(24'd7 + 24'(i), 2'(i), i == 3);
         apply_stimulus(24'd7 + 24'(i), i == 3);
      end
      drain("frame_err");
      check_output("frame_err_sticky", 32'(frame_err_o), 32'd1);

      // Test 6a: gain change after ch1 only applies from the next frame.
      expect_beat(24'h000100, 2'd0, 1'b0);
      apply_stimulus(24'h000100, 1'b0);
      expect_beat(24'h000100, 2'd1, 1'b0);
      apply_stimulus(24'h000100, 1'b0);
      gains_i = G_HALF;
      expect_beat(24'h000100, 2'd2, 1'b0);
      apply_stimulus(24'h000100, 1'b0);
      expect_beat(24'h000100, 2'd3, 1'b1);
      apply_stimulus(24'h000100, 1'b1);
      for (int i = 0; i < 4; i++) begin
         expect_beat(24'h000080, 2'(i), i == 3);
         apply_stimulus(24'h000100, i == 3);
      end
      drain("shadow");

      // Test 6b: reset with two samples held in the stalled pipeline.
      rdy_force = 1'b0;
      apply_stimulus(24'h000300, 1'b0);
      apply_stimulus(24'h000300, 1'b0);
      check_output("inflight_valid", 32'(m_axis_tvalid), 32'd1);
      areset = 1'b1;
      @(posedge aclk);
      #1;
      check_output("flush_valid", 32'(m_axis_tvalid), 32'd0);
      check_output("flush_frame_err", 32'(frame_err_o), 32'd0);
      check_output("flush_tdata", 32'(m_axis_tdata), 32'd0);
      @(posedge aclk);
      #1;
      areset    = 1'b0;
      rdy_force = 1'b1;
      repeat (4) @(posedge aclk);
      #1;
      check_output("no_ghost_valid", 32'(m_axis_tvalid), 32'd0);
      check_output("flush_sat_cnt", 32'(sat_cnt_o), 32'd0);
      expect_beat(24'h000080, 2'd0, 1'b0);
      apply_stimulus(24'h000100, 1'b0);
      drain("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
